keypad_debouncer: RTL and testbench

//   Sits directly downstream of the 4x4 keypad scan stage. Consumes its raw,

---
 rtl/keypad_debouncer.sv | 179 +++++++++++++++++
 tb/tb_keypad_debouncer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debouncer.sv
// keypad_debouncer
//   Cleans up the raw key code / key-down level coming from the 4x4 keypad
//   scan stage and turns every physical press into exactly one queued event.
//   The raw inputs are asynchronous, so both pass through two-flop
//   synchronizers before any decision is made. A press is accepted only after
//   the key-down level and key code have been stable for DEBOUNCE_CYCLES
//   cycles. A release is accepted under the same rule. Accepted presses go
//   into a small circular FIFO that is drained with a valid/ready handshake.
//
// Ports
//   CLOCK_50    in   1  system clock, rising edge
//   reset       in   1  synchronous, active-high reset
//   rawKey      in   4  raw key code (asynchronous)
//   rawValid    in   1  raw key-down level (asynchronous, bouncy)
//   out_key     out  4  key code at the FIFO head (0 while the FIFO is empty)
//   out_valid   out  1  FIFO non-empty
//   out_ready   in   1  consumer takes the head when out_valid & out_ready
//   key_held    out  1  debounced key-down level
//   held_key    out  4  code of the debounced held key, 0 when not held
//   fifo_level  out  5  number of queued events
//   overflow    out  1  sticky flag: a press was dropped on a full FIFO
module keypad_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] rawKey,
  input  logic       rawValid,
  output logic [3:0] out_key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       key_held,
  output logic [3:0] held_key,
  output logic [4:0] fifo_level,
  output logic       overflow
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]       LVL_FULL = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic             v_meta_q, v_s_q;
  logic [3:0]       k_meta_q, k_s_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cap_q, cap_d;
  logic             push_q, push_d;

  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]       level_q;
  logic             ovf_q;
  logic             fifo_full, do_pop, do_push;

  // Input synchronizers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      v_meta_q <= 1'b0;
      v_s_q    <= 1'b0;
      k_meta_q <= 4'd0;
      k_s_q    <= 4'd0;
    end else begin
      v_meta_q <= rawValid;
      v_s_q    <= v_meta_q;
      k_meta_q <= rawKey;
      k_s_q    <= k_meta_q;
    end
  end

  // Debounce FSM: state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= 4'd0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      push_q  <= push_d;
    end
  end

  // Debounce FSM: next state. A bounce (level drop or code change) has
  // priority over completing the stability window. The push request is
  // registered, so the event lands in the FIFO one cycle after HELD is
  // entered; cap_q cannot change in between because HELD never leaves
  // towards IDLE in a single step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    push_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
          cap_d   = k_s_q;
        end
      end
      PRESS_WAIT: begin
        if (!v_s_q || (k_s_q != cap_q)) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          push_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        // Rollover to another code while still pressed is ignored.
        if (!v_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (v_s_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Event FIFO. On a full FIFO a simultaneous pop frees the slot the push
  // writes into (wr_ptr == rd_ptr), so both proceed.
  assign fifo_full = (level_q == LVL_FULL);
  assign do_pop    = (level_q != 5'd0) & out_ready;
  assign do_push   = push_q & (!fifo_full | do_pop);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 5'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 5'd1;
        2'b01:   level_q <= level_q - 5'd1;
        default: level_q <= level_q;
      endcase
      if (push_q && fifo_full && !do_pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem_q[wr_ptr_q] <= cap_q;
  end

  // Outputs
  assign out_valid  = (level_q != 5'd0);
  assign out_key    = out_valid ? mem_q[rd_ptr_q] : 4'd0;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign key_held   = (state_q == HELD) || (state_q == RELEASE_WAIT);
  assign held_key   = key_held ? cap_q : 4'd0;

endmodule

// File: tb/tb_keypad_debouncer.sv
// tb_keypad_debouncer
//   Directed scenarios followed by randomized segments for keypad_debouncer
//   (DEBOUNCE_CYCLES=8, FIFO_DEPTH=4). A reference model describes the
//   debouncer as a debounced level plus the start time of a candidate level
//   change, and the FIFO as a queue.
module tb_keypad_debouncer;

  localparam int D     = 8;
  localparam int DEPTH = 4;

  logic       CLOCK_50  = 1'b0;
  logic       reset     = 1'b1;
  logic [3:0] rawKey    = 4'd0;
  logic       rawValid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] out_key;
  logic       out_valid;
  logic       key_held;
  logic [3:0] held_key;
  logic [4:0] fifo_level;
  logic       overflow;

  always #5 CLOCK_50 = ~CLOCK_50;

  keypad_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .rawKey    (rawKey),
    .rawValid  (rawValid),
    .out_key   (out_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .key_held  (key_held),
    .held_key  (held_key),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic       m_s1_v = 1'b0, m_s2_v = 1'b0;
  logic [3:0] m_s1_k = 4'd0, m_s2_k = 4'd0;
  bit         m_down = 1'b0;         // debounced key-down level
  longint     m_cand = -1;           // edge at which a candidate change began, -1 none
  logic [3:0] m_key  = 4'd0;         // code of the press being qualified / held
  bit         m_push_pend = 1'b0;
  logic [3:0] m_push_key  = 4'd0;
  int         m_q[$];
  bit         m_ovf  = 1'b0;
  longint     m_edge = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit v, input logic [3:0] k, input bit rdy, input bit rst);
    bit pop;
    m_edge++;
    if (rst) begin
      m_s1_v = 1'b0; m_s2_v = 1'b0; m_s1_k = 4'd0; m_s2_k = 4'd0;
      m_down = 1'b0; m_cand = -1; m_key = 4'd0;
      m_push_pend = 1'b0; m_q.delete(); m_ovf = 1'b0;
    end else begin
      pop = (m_q.size() != 0) && rdy;
      if (m_push_pend && m_q.size() == DEPTH && !pop) begin
        m_ovf = 1'b1;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_push_pend) m_q.push_back(int'(m_push_key));
      end
      m_push_pend = 1'b0;
      if (!m_down) begin
        if (m_cand < 0) begin
          if (m_s2_v) begin m_cand = m_edge; m_key = m_s2_k; end
        end else if (!m_s2_v || m_s2_k != m_key) begin
          m_cand = -1;
        end else if (m_edge - m_cand == D) begin
          m_down = 1'b1; m_cand = -1; m_push_pend = 1'b1; m_push_key = m_key;
        end
      end else begin
        if (m_cand < 0) begin
          if (!m_s2_v) m_cand = m_edge;
        end else if (m_s2_v) begin
          m_cand = -1;
        end else if (m_edge - m_cand == D) begin
          m_down = 1'b0; m_cand = -1;
        end
      end
      m_s2_v = m_s1_v; m_s2_k = m_s1_k;
      m_s1_v = v;      m_s1_k = k;
    end
  endtask

  task automatic compare_all();
    int lvl;
    logic [3:0] ek, eh;
    lvl = m_q.size();
    ek  = (lvl != 0) ? 4'(m_q[0]) : 4'd0;
    eh  = m_down ? m_key : 4'd0;
    chk("mdl_out_valid",  8'(out_valid),  8'(lvl != 0));
    chk("mdl_out_key",    8'(out_key),    8'(ek));
    chk("mdl_fifo_level", 8'(fifo_level), 8'(lvl));
    chk("mdl_key_held",   8'(key_held),   8'(m_down));
    chk("mdl_held_key",   8'(held_key),   8'(eh));
    chk("mdl_overflow",   8'(overflow),   8'(m_ovf));
  endtask

  task automatic tick(input bit v, input logic [3:0] k, input bit rdy, input bit rst);
    rawValid  = v;
    rawKey    = k;
    out_ready = rdy;
    reset     = rst;
    @(posedge CLOCK_50);
    model_edge(v, k, rdy, rst);
    #1;
    compare_all();
  endtask

  task automatic clean_press(input logic [3:0] k);
    for (int j = 0; j < 14; j++) tick(1'b1, k, 1'b0, 1'b0);
    for (int j = 0; j < 14; j++) tick(1'b0, k, 1'b0, 1'b0);
  endtask

  int keys4[5] = '{1, 2, 3, 4, 6};
  int keys5[4] = '{8, 9, 10, 11};

  initial begin
    bit         rv, rr, rs;
    logic [3:0] rk;
    int         len;

    // Reset state
    for (int j = 0; j < 3; j++) tick(1'b0, 4'd0, 1'b0, 1'b1);
    chk("rst_out_valid",  8'(out_valid),  8'd0);
    chk("rst_out_key",    8'(out_key),    8'd0);
    chk("rst_fifo_level", 8'(fifo_level), 8'd0);
    chk("rst_key_held",   8'(key_held),   8'd0);
    chk("rst_held_key",   8'(held_key),   8'd0);
    chk("rst_overflow",   8'(overflow),   8'd0);

    // 1. Clean press of key 5, consumer not ready
    for (int j = 0; j < 30; j++) begin
      tick(1'b1, 4'd5, 1'b0, 1'b0);
      chk("t1_out_valid", 8'(out_valid), 8'(j >= 11));
      chk("t1_key_held",  8'(key_held),  8'(j >= 10));
    end
    chk("t1_out_key",    8'(out_key),    8'd5);
    chk("t1_fifo_level", 8'(fifo_level), 8'd1);
    chk("t1_held_key",   8'(held_key),   8'd5);
    for (int j = 0; j < 20; j++) tick(1'b0, 4'd5, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    chk("t1_drained", 8'(fifo_level), 8'd0);

    // 2. Press bounce, then a solid press of key 3
    for (int i = 0; i < 40; i++) tick(((i / 3) % 2) == 0, 4'd3, 1'b0, 1'b0);
    for (int j = 0; j < 30; j++) begin
      tick(1'b1, 4'd3, 1'b0, 1'b0);
      chk("t2_key_held",   8'(key_held),   8'(j >= 10));
      chk("t2_fifo_level", 8'(fifo_level), 8'(j >= 11));
    end
    tick(1'b1, 4'd3, 1'b1, 1'b0);
    chk("t2_drained", 8'(fifo_level), 8'd0);

    // 3. Release bounce while held
    for (int j = 0; j < 4; j++) begin
      tick(1'b0, 4'd3, 1'b0, 1'b0);
      chk("t3_hold_a", 8'(key_held), 8'd1);
    end
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, 4'd3, 1'b0, 1'b0);
      chk("t3_hold_b", 8'(key_held), 8'd1);
    end
    for (int j = 0; j < 20; j++) begin
      tick(1'b0, 4'd3, 1'b0, 1'b0);
      chk("t3_key_held",   8'(key_held),   8'(j < 10));
      chk("t3_fifo_level", 8'(fifo_level), 8'd0);
    end

    // 4. Five presses into a four-deep FIFO
    for (int p = 0; p < 5; p++) clean_press(4'(keys4[p]));
    chk("t4_fifo_level", 8'(fifo_level), 8'd4);
    chk("t4_overflow",   8'(overflow),   8'd1);
    for (int e = 0; e < 4; e++) begin
      chk("t4_drain_key", 8'(out_key), 8'(keys4[e]));
      tick(1'b0, 4'd0, 1'b1, 1'b0);
    end
    chk("t4_empty_valid", 8'(out_valid), 8'd0);
    chk("t4_ovf_sticky",  8'(overflow),  8'd1);

    // 5. Push and pop on the same cycle with a full FIFO
    for (int j = 0; j < 2; j++) tick(1'b0, 4'd0, 1'b0, 1'b1);
    clean_press(4'd7); clean_press(4'd8); clean_press(4'd9); clean_press(4'd10);
    chk("t5_full", 8'(fifo_level), 8'd4);
    for (int j = 0; j < 14; j++) tick(1'b1, 4'd11, (j == 11), 1'b0);
    chk("t5_fifo_level", 8'(fifo_level), 8'd4);
    chk("t5_overflow",   8'(overflow),   8'd0);
    chk("t5_head",       8'(out_key),    8'd8);
    for (int j = 0; j < 14; j++) tick(1'b0, 4'd11, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) begin
      chk("t5_drain_key", 8'(out_key), 8'(keys5[e]));
      tick(1'b0, 4'd0, 1'b1, 1'b0);
    end

    // 6. Reset during a press with two events queued
    for (int j = 0; j < 2; j++) tick(1'b0, 4'd0, 1'b0, 1'b1);
    clean_press(4'd2); clean_press(4'd3);
    for (int j = 0; j < 5; j++) tick(1'b1, 4'd9, 1'b0, 1'b0);
    chk("t6_queued", 8'(fifo_level), 8'd2);
    tick(1'b1, 4'd9, 1'b0, 1'b1);
    chk("t6_out_valid",  8'(out_valid),  8'd0);
    chk("t6_out_key",    8'(out_key),    8'd0);
    chk("t6_fifo_level", 8'(fifo_level), 8'd0);
    chk("t6_key_held",   8'(key_held),   8'd0);
    chk("t6_held_key",   8'(held_key),   8'd0);
    chk("t6_overflow",   8'(overflow),   8'd0);
    for (int j = 0; j < 14; j++) begin
      tick(1'b1, 4'd9, 1'b0, 1'b0);
      chk("t6_fresh_valid", 8'(out_valid), 8'(j >= 11));
    end
    chk("t6_fresh_key", 8'(out_key), 8'd9);

    // Randomized segments against the reference model
    for (int s = 0; s < 60; s++) begin
      rv  = 1'($urandom_range(0, 1));
      rk  = 4'($urandom_range(0, 3));
      len = int'($urandom_range(1, 16));
      for (int j = 0; j < len; j++) begin
        rr = ($urandom_range(0, 3) == 0);
        rs = ($urandom_range(0, 199) == 0);
        tick(rv, rk, rr, rs);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
